temp_ctrl_fsm: RTL
==================

// Module: temp_ctrl_fsm
// PURPOSE
//  Thermal control sequencer behind the SPI subordinate APB interface.
//  - Consumes each temperature byte as it is loaded.
//  - Compares it against CPU-programmed thresholds with debounce and hysteresis.
//  - Drives fan/heater enables and the 2-bit state that the interface exposes in STATUS.
//  - Escalates to FAULT when cooling or heating fails to recover within a sample budget.
// PARAMETERS
//  DEBOUNCE  3   consecutive out-of-band samples required to leave NORMAL (1..15)
//  HYST      2   hysteresis in degrees (LSBs) applied when returning to NORMAL
//  MAX_SMP   64  samples allowed in COOLING/HEATING before FAULT (1..255)
// PORTS
//  pclk         in   1  clock
//  presetn      in   1  asynchronous active-low reset
//  en           in   1  controller enable; low forces NORMAL and clears counters
//  temp_valid   in   1  1-cycle strobe: temp_data holds a new sample
//  temp_data    in   8  unsigned temperature sample
//  high_thr     in   8  upper threshold, unsigned
//  low_thr      in   8  lower threshold, unsigned
//  clear_fault  in   1  1-cycle strobe: leave FAULT
//  fan_on       out  1  fan enable (registered)
//  heater_on    out  1  heater enable (registered)
//  state        out  2  00 NORMAL, 01 COOLING, 10 HEATING, 11 FAULT
//  fault_irq    out  1  1-cycle pulse on entry to FAULT
//  cfg_err      out  1  level: low_thr >= high_thr
//  min_temp     out  8  lowest sample since reset (macro only)
//  max_temp     out  8  highest sample since reset (macro only)
// BEHAVIOUR
//  - Reset: state=NORMAL, fan_on=0, heater_on=0, fault_irq=0, all counters=0; cfg_err reflects inputs combinationally.
//  - Timing: all outputs except cfg_err are registered.
//  - Sample processing: only on cycles with temp_valid=1 and en=1; the state update is visible the next cycle.
//  - Recovery bounds: hi_ret = sat0(high_thr-HYST), lo_ret = sat255(low_thr+HYST); 9-bit intermediates.
//  - NORMAL:
//    - temp > high_thr increments hi_cnt and clears lo_cnt.
//    - temp < low_thr increments lo_cnt and clears hi_cnt.
//    - Otherwise both counters clear.
//    - When a counter reaches DEBOUNCE, go to COOLING or HEATING respectively; smp_cnt is cleared.
//  - COOLING (fan_on=1):
//    - temp <= hi_ret: go to NORMAL.
//    - Otherwise smp_cnt++; when smp_cnt reaches MAX_SMP: go to FAULT and pulse fault_irq.
//  - HEATING (heater_on=1): mirror of COOLING using temp >= lo_ret.
//  - FAULT:
//    - fan_on=0, heater_on=0; samples are ignored.
//    - clear_fault: go to NORMAL with all counters cleared.
//  - Priority: clear_fault over temp_valid in the same cycle; that sample is discarded.
//  - cfg_err=1 forces NORMAL with outputs off and counters cleared. FAULT is also cleared.
//  - en=0 behaves the same as cfg_err=1. fault_irq is never asserted while en=0.
//  - fan_on and heater_on are never both 1.
//  - Counters saturate and never wrap.
//  - Reset mid-operation returns to reset values immediately (async).
// CONFIGURATION
//  TEMP_CTRL_MINMAX_EN defined:
//    - min_temp and max_temp track every valid sample regardless of state or en.
//    - Reset values: min_temp=8'hFF, max_temp=8'h00.
//  Not defined: min_temp and max_temp are tied to 8'h00 and no flops are inferred.
// TESTING
//  T1 thr 20/40: samples 41,41,41 -> COOLING and fan_on=1 one cycle after the 3rd strobe.
//     Then 39 -> stays COOLING; 38 -> NORMAL, fan_on=0.
//  T2 samples 41,41,30,41 -> stays NORMAL (debounce restart).
//     Samples 19x3 -> HEATING; then 22 -> NORMAL.
//  T3 MAX_SMP=4: enter COOLING, then 4 samples of 50.
//     -> FAULT, fault_irq single pulse, fan_on=0.
//     clear_fault together with temp_valid=50 -> NORMAL, hi_cnt=0.
//  T4 low_thr=40, high_thr=40 -> cfg_err=1.
//     Samples 200x5 -> NORMAL, outputs 0.
//     Restore low_thr=20 -> normal debounce resumes from 0.
//  T5 high_thr=1, HYST=2: hi_ret saturates to 0.
//     Enter COOLING; sample 0 -> NORMAL.
//     low_thr=254: lo_ret saturates to 255.
//  T6 presetn low while in HEATING -> state=00 and heater_on=0 without waiting for a clock edge.
//     With the macro defined: samples 30,10,50 -> min=10, max=50.

Source files
------------

// File: rtl/temp_ctrl_fsm.sv
// temp_ctrl_fsm: thermal control sequencer. Debounces each temperature sample
// against the programmed thresholds, drives fan/heater enables and escalates
// to FAULT when cooling or heating does not recover within MAX_SMP samples.
// Optional build macro: TEMP_CTRL_MINMAX_EN (min/max sample tracking).
//
// state   | meaning
// --------+---------------------------------------------------------------
// NORMAL  | temperature in band, debounce counters active, outputs off
// COOLING | fan on, waiting for temp <= hi_ret, sample budget running
// HEATING | heater on, waiting for temp >= lo_ret, sample budget running
// FAULT   | recovery budget exhausted, outputs off until clear_fault
module temp_ctrl_fsm #(
   parameter int DEBOUNCE = 3,
   parameter int HYST     = 2,
   parameter int MAX_SMP  = 64
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       en,
   input  logic       temp_valid,
   input  logic [7:0] temp_data,
   input  logic [7:0] high_thr,
   input  logic [7:0] low_thr,
   input  logic       clear_fault,
   output logic       fan_on,
   output logic       heater_on,
   output logic [1:0] state,
   output logic       fault_irq,
   output logic       cfg_err,
   output logic [7:0] min_temp,
   output logic [7:0] max_temp
);

   localparam logic [1:0] ST_NORMAL  = 2'b00;
   localparam logic [1:0] ST_COOLING = 2'b01;
   localparam logic [1:0] ST_HEATING = 2'b10;
   localparam logic [1:0] ST_FAULT   = 2'b11;

   localparam logic [3:0] DEB_TC = 4'(DEBOUNCE);
   localparam logic [7:0] SMP_LD = 8'(MAX_SMP);
   localparam logic [8:0] HYST9  = 9'(HYST);

   logic [1:0] state_nxt;
   logic [3:0] hi_cnt, hi_cnt_nxt, hi_cnt_inc;
   logic [3:0] lo_cnt, lo_cnt_nxt, lo_cnt_inc;
   // Recovery budget as a down-counter: loaded with MAX_SMP on entry, FAULT at terminal count.
   logic [7:0] smp_left, smp_left_nxt;
   logic [8:0] hi_ret9, lo_ret9;
   logic [7:0] hi_ret, lo_ret;
   logic       force_idle;

   assign cfg_err    = (low_thr >= high_thr);
   assign force_idle = !en || cfg_err;

   // Borrow into bit 8 means high_thr < HYST: clamp to 0. Carry means > 255: clamp to 255.
   assign hi_ret9 = {1'b0, high_thr} - HYST9;
   assign lo_ret9 = {1'b0, low_thr} + HYST9;
   assign hi_ret  = hi_ret9[8] ? 8'h00 : hi_ret9[7:0];
   assign lo_ret  = lo_ret9[8] ? 8'hFF : lo_ret9[7:0];

   assign hi_cnt_inc = (hi_cnt == 4'hF) ? hi_cnt : hi_cnt + 4'd1;
   assign lo_cnt_inc = (lo_cnt == 4'hF) ? lo_cnt : lo_cnt + 4'd1;

   // Next-state and counter update; only valid samples advance the sequencer.
   always_comb begin
      state_nxt    = state;
      hi_cnt_nxt   = hi_cnt;
      lo_cnt_nxt   = lo_cnt;
      smp_left_nxt = smp_left;
      if (force_idle) begin
         state_nxt    = ST_NORMAL;
         hi_cnt_nxt   = 4'd0;
         lo_cnt_nxt   = 4'd0;
         smp_left_nxt = 8'd0;
      end else begin
         case (state)
            ST_NORMAL: begin
               if (temp_valid) begin
                  if (temp_data > high_thr) begin
                     lo_cnt_nxt = 4'd0;
                     hi_cnt_nxt = hi_cnt_inc;
                     if (hi_cnt_inc >= DEB_TC) begin
                        state_nxt    = ST_COOLING;
                        hi_cnt_nxt   = 4'd0;
                        smp_left_nxt = SMP_LD;
                     end
                  end else if (temp_data < low_thr) begin
                     hi_cnt_nxt = 4'd0;
                     lo_cnt_nxt = lo_cnt_inc;
                     if (lo_cnt_inc >= DEB_TC) begin
                        state_nxt    = ST_HEATING;
                        lo_cnt_nxt   = 4'd0;
                        smp_left_nxt = SMP_LD;
                     end
                  end else begin
                     hi_cnt_nxt = 4'd0;
                     lo_cnt_nxt = 4'd0;
                  end
               end
            end
            ST_COOLING: begin
               if (temp_valid) begin
                  if (temp_data <= hi_ret) begin
                     state_nxt    = ST_NORMAL;
                     smp_left_nxt = 8'd0;
                  end else if (smp_left <= 8'd1) begin
                     state_nxt    = ST_FAULT;
                     smp_left_nxt = 8'd0;
                  end else begin
                     smp_left_nxt = smp_left - 8'd1;
                  end
               end
            end
            ST_HEATING: begin
               if (temp_valid) begin
                  if (temp_data >= lo_ret) begin
                     state_nxt    = ST_NORMAL;
                     smp_left_nxt = 8'd0;
                  end else if (smp_left <= 8'd1) begin
                     state_nxt    = ST_FAULT;
                     smp_left_nxt = 8'd0;
                  end else begin
                     smp_left_nxt = smp_left - 8'd1;
                  end
               end
            end
            default: begin
               // FAULT ignores samples; a clear in the same cycle as a sample drops that sample.
               if (clear_fault) begin
                  state_nxt    = ST_NORMAL;
                  hi_cnt_nxt   = 4'd0;
                  lo_cnt_nxt   = 4'd0;
                  smp_left_nxt = 8'd0;
               end
            end
         endcase
      end
   end

   // State, counters and registered outputs; outputs decode the next state so they align with it.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= ST_NORMAL;
         hi_cnt    <= 4'd0;
         lo_cnt    <= 4'd0;
         smp_left  <= 8'd0;
         fan_on    <= 1'b0;
         heater_on <= 1'b0;
         fault_irq <= 1'b0;
      end else begin
         state     <= state_nxt;
         hi_cnt    <= hi_cnt_nxt;
         lo_cnt    <= lo_cnt_nxt;
         smp_left  <= smp_left_nxt;
         fan_on    <= (state_nxt == ST_COOLING);
         heater_on <= (state_nxt == ST_HEATING);
         fault_irq <= (state_nxt == ST_FAULT) && (state != ST_FAULT);
      end
   end

`ifdef TEMP_CTRL_MINMAX_EN
   // Extremes of every valid sample since reset, independent of state and en.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         min_temp <= 8'hFF;
         max_temp <= 8'h00;
      end else if (temp_valid) begin
         if (temp_data < min_temp) min_temp <= temp_data;
         if (temp_data > max_temp) max_temp <= temp_data;
      end
   end
`else
   assign min_temp = 8'h00;
   assign max_temp = 8'h00;
`endif

endmodule
